// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Cascaded horizontal/vertical pixel counters with registered VGA
//            sync, blanking and line/frame strobes, all aligned to the counters.
//            Define VGA_TIMING_FRAME_CNT_EN to add the completed-frame counter.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int CNT_W     = 12,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int FRAME_W   = 8
) (
  input  logic             pix_clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             line_end,
  output logic             frame_end
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [FRAME_W-1:0] frame_cnt
`endif
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] c_H_LAST     = CNT_W'(c_H_TOTAL - 1);
  localparam logic [CNT_W-1:0] c_V_LAST     = CNT_W'(c_V_TOTAL - 1);
  localparam logic [CNT_W-1:0] c_H_ACT      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] c_V_ACT      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] c_HS_START   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] c_HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] c_VS_START   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] c_VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Reject geometries the counters cannot represent.
  if ((c_H_TOTAL - 1) >= (1 << CNT_W)) begin : g_chk_h_width
    $error("vga_timing_gen: H_TOTAL-1 does not fit in CNT_W bits");
  end
  if ((c_V_TOTAL - 1) >= (1 << CNT_W)) begin : g_chk_v_width
    $error("vga_timing_gen: V_TOTAL-1 does not fit in CNT_W bits");
  end
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_chk_h_zero
    $error("vga_timing_gen: horizontal timing parameters must be non-zero");
  end
  if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_chk_v_zero
    $error("vga_timing_gen: vertical timing parameters must be non-zero");
  end
  if (FRAME_W < 1) begin : g_chk_frame_w
    $error("vga_timing_gen: FRAME_W must be at least 1");
  end

  logic [CNT_W-1:0] r_hcount;
  logic [CNT_W-1:0] r_vcount;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_video_on;
  logic             r_line_end;
  logic             r_frame_end;

  logic             w_h_last;
  logic             w_v_last;
  logic [CNT_W-1:0] w_h_nxt;
  logic [CNT_W-1:0] w_v_nxt;
  logic             w_hs_act;
  logic             w_vs_act;
  logic             w_vid_nxt;
  logic             w_le_nxt;
  logic             w_fe_nxt;

  // Decode is taken from the next counter values so every registered output
  // lines up with the counter value it describes.
  always_comb begin
    w_h_last  = (r_hcount == c_H_LAST);
    w_v_last  = (r_vcount == c_V_LAST);
    w_h_nxt   = w_h_last ? '0 : r_hcount + 1'b1;
    w_v_nxt   = r_vcount;
    if (w_h_last) begin
      w_v_nxt = w_v_last ? '0 : r_vcount + 1'b1;
    end
    w_hs_act  = (w_h_nxt >= c_HS_START) && (w_h_nxt <= c_HS_END);
    w_vs_act  = (w_v_nxt >= c_VS_START) && (w_v_nxt <= c_VS_END);
    w_vid_nxt = (w_h_nxt < c_H_ACT) && (w_v_nxt < c_V_ACT);
    w_le_nxt  = (w_h_nxt == c_H_LAST);
    w_fe_nxt  = (w_h_nxt == c_H_LAST) && (w_v_nxt == c_V_LAST);
  end

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcount    <= '0;
      r_vcount    <= '0;
      r_hsync     <= ~HSYNC_POL;
      r_vsync     <= ~VSYNC_POL;
      r_video_on  <= 1'b1;
      r_line_end  <= 1'b0;
      r_frame_end <= 1'b0;
    end else if (en) begin
      r_hcount    <= w_h_nxt;
      r_vcount    <= w_v_nxt;
      r_hsync     <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
      r_vsync     <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
      r_video_on  <= w_vid_nxt;
      r_line_end  <= w_le_nxt;
      r_frame_end <= w_fe_nxt;
    end
  end

  assign hcount    = r_hcount;
  assign vcount    = r_vcount;
  assign hsync     = r_hsync;
  assign vsync     = r_vsync;
  assign video_on  = r_video_on;
  assign line_end  = r_line_end;
  assign frame_end = r_frame_end;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_W-1:0] r_frame_cnt;

  // Counts on the edge that leaves the terminal (last pixel, last line) state.
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (en && w_h_last && w_v_last) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Scoreboard bench for vga_timing_gen: default 640x480 geometry and
//            a tiny active-high-sync geometry for whole-frame behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  typedef struct packed {
    logic [11:0] h;
    logic [11:0] v;
    logic        hs;
    logic        vs;
    logic        vo;
    logic        le;
    logic        fe;
    logic [7:0]  fc;
  } exp_t;

  logic        pix_clk;
  logic        rst_n_a, rst_n_b;
  logic        en_a, en_b;
  logic [11:0] hcount_a, vcount_a;
  logic [3:0]  hcount_b, vcount_b;
  logic        hsync_a, vsync_a, video_on_a, line_end_a, frame_end_a;
  logic        hsync_b, vsync_b, video_on_b, line_end_b, frame_end_b;
  logic [7:0]  fc_a;
  logic [1:0]  fc_b;

  int n_asrt = 0;
  int n_fail = 0;

  exp_t qa[$];
  exp_t qb[$];

  // Reference state for each instance.
  int ah = 0, av = 0, afc = 0;
  int bh = 0, bv = 0, bfc = 0;

  vga_timing_gen u_dut_a (
    .pix_clk   (pix_clk),
    .rst_n     (rst_n_a),
    .en        (en_a),
    .hcount    (hcount_a),
    .vcount    (vcount_a),
    .hsync     (hsync_a),
    .vsync     (vsync_a),
    .video_on  (video_on_a),
    .line_end  (line_end_a),
    .frame_end (frame_end_a)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .frame_cnt (fc_a)
`endif
  );

  vga_timing_gen #(
    .CNT_W(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .FRAME_W(2)
  ) u_dut_b (
    .pix_clk   (pix_clk),
    .rst_n     (rst_n_b),
    .en        (en_b),
    .hcount    (hcount_b),
    .vcount    (vcount_b),
    .hsync     (hsync_b),
    .vsync     (vsync_b),
    .video_on  (video_on_b),
    .line_end  (line_end_b),
    .frame_end (frame_end_b)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .frame_cnt (fc_b)
`endif
  );

`ifndef VGA_TIMING_FRAME_CNT_EN
  assign fc_a = '0;
  assign fc_b = '0;
`endif

  initial pix_clk = 1'b0;
  always #5 pix_clk = ~pix_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asrt++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Default geometry: 800x525, sync active-low at h 656..751 / v 490..491.
  function automatic exp_t mk_a(int h, int v, int fc);
    exp_t x;
    x.h  = 12'(h);
    x.v  = 12'(v);
    x.hs = (h >= 656 && h <= 751) ? 1'b0 : 1'b1;
    x.vs = (v >= 490 && v <= 491) ? 1'b0 : 1'b1;
    x.vo = (h < 640) && (v < 480);
    x.le = (h == 799);
    x.fe = (h == 799) && (v == 524);
    x.fc = 8'(fc);
    return x;
  endfunction

  // Small geometry: 15x8, sync active-high at h 10..12 / v 5..6.
  function automatic exp_t mk_b(int h, int v, int fc);
    exp_t x;
    x.h  = 12'(h);
    x.v  = 12'(v);
    x.hs = (h >= 10 && h <= 12);
    x.vs = (v >= 5 && v <= 6);
    x.vo = (h < 8) && (v < 4);
    x.le = (h == 14);
    x.fe = (h == 14) && (v == 7);
    x.fc = 8'(fc);
    return x;
  endfunction

  task automatic cmp_a();
    exp_t x = qa.pop_front();
    chk("A.hcount", 32'(hcount_a), 32'(x.h));
    chk("A.vcount", 32'(vcount_a), 32'(x.v));
    chk("A.hsync", 32'(hsync_a), 32'(x.hs));
    chk("A.vsync", 32'(vsync_a), 32'(x.vs));
    chk("A.video_on", 32'(video_on_a), 32'(x.vo));
    chk("A.line_end", 32'(line_end_a), 32'(x.le));
    chk("A.frame_end", 32'(frame_end_a), 32'(x.fe));
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("A.frame_cnt", 32'(fc_a), 32'(x.fc));
`endif
  endtask

  task automatic cmp_b();
    exp_t x = qb.pop_front();
    chk("B.hcount", 32'(hcount_b), 32'(x.h));
    chk("B.vcount", 32'(vcount_b), 32'(x.v));
    chk("B.hsync", 32'(hsync_b), 32'(x.hs));
    chk("B.vsync", 32'(vsync_b), 32'(x.vs));
    chk("B.video_on", 32'(video_on_b), 32'(x.vo));
    chk("B.line_end", 32'(line_end_b), 32'(x.le));
    chk("B.frame_end", 32'(frame_end_b), 32'(x.fe));
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("B.frame_cnt", 32'(fc_b), 32'(x.fc));
`endif
  endtask

  task automatic step_a(input bit e);
    en_a = e;
    if (e) begin
      if (ah == 799) begin
        ah = 0;
        if (av == 524) begin av = 0; afc = (afc + 1) % 256; end
        else av++;
      end else ah++;
    end
    qa.push_back(mk_a(ah, av, afc));
    @(posedge pix_clk); #1;
    cmp_a();
  endtask

  task automatic step_b(input bit e);
    en_b = e;
    if (e) begin
      if (bh == 14) begin
        bh = 0;
        if (bv == 7) begin bv = 0; bfc = (bfc + 1) % 4; end
        else bv++;
      end else bh++;
    end
    qb.push_back(mk_b(bh, bv, bfc));
    @(posedge pix_clk); #1;
    cmp_b();
  endtask

  initial begin
    int hs_low;
    int le_cnt;
    int fe_rise;
    int wraps;
    int seq[5];
    bit was_term;
    bit prev_fe;
    seq = '{1, 2, 3, 0, 1};

    rst_n_a = 1'b0; rst_n_b = 1'b0;
    en_a = 1'b0; en_b = 1'b0;
    @(posedge pix_clk); #1;
    qa.push_back(mk_a(0, 0, 0)); cmp_a();
    qb.push_back(mk_b(0, 0, 0)); cmp_b();

    // ---- Instance A: one full line plus a little.
    rst_n_a = 1'b1;
    hs_low = 0; le_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      step_a(1'b1);
      if (hsync_a === 1'b0) hs_low++;
      if (line_end_a === 1'b1) le_cnt++;
    end
    chk("A.hsync_low_cycles", 32'(hs_low), 32'd96);
    chk("A.line_end_cycles", 32'(le_cnt), 32'd1);
    chk("A.vcount_after_800", 32'(vcount_a), 32'd1);

    // Stall at hcount 100, then resume.
    for (int i = 0; i < 100; i++) step_a(1'b1);
    for (int i = 0; i < 10; i++) step_a(1'b0);
    step_a(1'b1);
    chk("A.resume_hcount", 32'(hcount_a), 32'd101);

    // Asynchronous reset in the middle of hsync.
    for (int i = 0; i < 800 && ah != 700; i++) step_a(1'b1);
    chk("A.hsync_before_rst", 32'(hsync_a), 32'd0);
    rst_n_a = 1'b0;
    ah = 0; av = 0; afc = 0;
    qa.push_back(mk_a(0, 0, 0));
    #2;
    cmp_a();
    en_a = 1'b1;
    qa.push_back(mk_a(0, 0, 0));
    @(posedge pix_clk); #1;
    cmp_a();
    rst_n_a = 1'b1;
    step_a(1'b1);
    step_a(1'b1);
    en_a = 1'b0;

    // ---- Instance B: five frames with a stall on the terminal pixel.
    rst_n_b = 1'b1;
    wraps = 0; fe_rise = 0; prev_fe = 1'b0;
    for (int i = 0; i < 800 && wraps < 5; i++) begin
      was_term = (bh == 14) && (bv == 7);
      if (was_term && wraps == 0) begin
        for (int k = 0; k < 3; k++) step_b(1'b0);
      end
      step_b(1'b1);
      if (frame_end_b === 1'b1 && !prev_fe) fe_rise++;
      prev_fe = (frame_end_b === 1'b1);
      if (was_term) begin
        chk("B.wrap_origin", 32'({hcount_b, vcount_b}), 32'd0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("B.frame_cnt_seq", 32'(fc_b), 32'(seq[wraps]));
`endif
        wraps++;
      end
    end
    chk("B.frame_end_pulses", 32'(fe_rise), 32'd5);

    // Asynchronous reset inside both sync pulses.
    for (int i = 0; i < 200 && !(bh == 11 && bv == 5); i++) step_b(1'b1);
    chk("B.sync_before_rst", 32'({hsync_b, vsync_b}), 32'd3);
    rst_n_b = 1'b0;
    bh = 0; bv = 0; bfc = 0;
    qb.push_back(mk_b(0, 0, 0));
    #2;
    cmp_b();
    rst_n_b = 1'b1;
    step_b(1'b1);
    chk("B.restart_hcount", 32'(hcount_b), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the single free-running pixel counter: a cascaded horizontal/vertical counter pair with full VGA timing decode.
- Generates hcount/vcount plus hsync, vsync, video_on, and line/frame boundary strobes from one pixel clock.
- Sits between the pixel clock domain root and the character/pixel renderer.
- Replaces ad-hoc per-axis counters plus external compare logic.

Parameters:
- CNT_W, 12, width of hcount/vcount.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, horizontal sync width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width (lines).
- V_BP, 33, vertical back porch (lines).
- HSYNC_POL, 0, asserted level of hsync.
- VSYNC_POL, 0, asserted level of vsync.
- FRAME_W, 8, frame counter width (used only with the optional feature).

Ports:
- pix_clk  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  count enable; when low, all state holds.
- hcount  out  CNT_W  horizontal position, 0..H_TOTAL-1.
- vcount  out  CNT_W  vertical position, 0..V_TOTAL-1.
- hsync  out  1  horizontal sync, polarity per HSYNC_POL.
- vsync  out  1  vertical sync, polarity per VSYNC_POL.
- video_on  out  1  high inside the active region.
- line_end  out  1  high while hcount == H_TOTAL-1.
- frame_end  out  1  high while hcount == H_TOTAL-1 and vcount == V_TOTAL-1.
- frame_cnt  out  FRAME_W  completed-frame count; present only with FRAME_CNT_EN.

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Elaboration must fail if H_TOTAL-1 or V_TOTAL-1 exceeds 2^CNT_W-1, or if any timing parameter is 0.
- Reset (rst_n low): asynchronous, takes effect immediately without a clock edge. Output values while in reset:
  - hcount = 0, vcount = 0
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL
  - video_on = 1
  - line_end = 0, frame_end = 0, frame_cnt = 0
- Reset may assert mid-line or mid-frame with no restrictions. On the first enabled edge after release, hcount becomes 1.
- Counting, on each pix_clk edge with en = 1:
  - If hcount == H_TOTAL-1: hcount <= 0, and vcount <= (vcount == V_TOTAL-1) ? 0 : vcount+1.
  - Otherwise: hcount <= hcount+1 and vcount holds.
- en = 0: every register holds, including all decoded outputs. No strobe is regenerated or extended by the stall.
- All outputs are registered and aligned with hcount/vcount in the same cycle, so there is no pipeline offset. Decode is computed from the next-state counter values, so there is zero latency relative to the counters.
- hsync is asserted (= HSYNC_POL) iff H_ACTIVE+H_FP <= hcount <= H_ACTIVE+H_FP+H_SYNC-1. Default range is 656..751.
- vsync is asserted (= VSYNC_POL) iff V_ACTIVE+V_FP <= vcount <= V_ACTIVE+V_FP+V_SYNC-1. Default range is 490..491. vsync changes only at line boundaries.
- video_on = (hcount < H_ACTIVE) && (vcount < V_ACTIVE).
- Strobes:
  - line_end and frame_end are single-cycle when en is held high.
  - They stay high across stalls while the counter sits on the terminal value.
- Wrap-around: from (H_TOTAL-1, V_TOTAL-1) the next enabled edge goes to (0,0), and frame_end deasserts.
- No arithmetic overflow is possible beyond the declared ranges.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- Defined:
  - The frame_cnt port exists.
  - frame_cnt increments on the enabled edge leaving frame_end (the (H_TOTAL-1, V_TOTAL-1) -> (0,0) transition).
  - It wraps modulo 2^FRAME_W and resets to 0.
- Undefined: the port and register are absent; FRAME_W is ignored; all other behaviour is identical.

Test Plan:
- Release rst_n, en = 1, default params, 800 clocks:
  - hcount steps 0..799 then 0.
  - vcount goes 0->1 on the 800th edge.
  - line_end is high only at hcount = 799.
- Same run, observe hsync: low for exactly hcount 656..751 (96 cycles) and high elsewhere. With HSYNC_POL = 1, the inverse.
- Run a full frame (420000 clocks):
  - vsync is low only for vcount 490..491.
  - video_on is high only for hcount < 640 and vcount < 480.
  - frame_end is high for one cycle at (799,524), followed by (0,0).
- Drop en at hcount = 100 for 10 cycles:
  - All outputs are frozen at hcount = 100.
  - Counting resumes at 101 on the first edge with en = 1.
- Assert rst_n low between edges at (700,491):
  - Immediately hcount = 0, vcount = 0, hsync = 1, vsync = 1, video_on = 1.
  - After release, counting restarts from 0.
- With VGA_TIMING_FRAME_CNT_EN and FRAME_W = 2, run 5 frames: frame_cnt sequence is 1, 2, 3, 0, 1 at each frame wrap.
